// File: rtl/program_memory.sv
// program_memory: 16x8 instruction store with byte-serial loader.
// Holds the cpu in reset while a program is loaded, then releases it.
//
// Ports:
//   clk, reset          clock; async active-high reset (sync deassert inside)
//   addr / data         cpu fetch address / combinational instruction out
//   load_start          request a (re)load, sampled every cycle
//   load_valid/ready    byte handshake, accepted on posedge when both high
//   load_data           program byte, address order from 0
//   load_done           one-cycle pulse after the last word is written
//   loading             high while in LOAD
//   cpu_n_reset         cpu reset, low = cpu held in reset
module program_memory #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              loading,
    output logic              cpu_n_reset
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        HALT    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [1:0]        rst_sync_q;
    logic              rst_int;
    logic              wr_en;

    // Reset asserts immediately, releases two edges after reset falls,
    // so no flop sees a reset release near the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    // A restart request takes priority over a byte on the same cycle.
    assign wr_en = (state_q == LOAD) && load_valid && !load_start;

    // State register
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q  <= HALT;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        unique case (state_q)
            HALT: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    wr_ptr_d = '0;
                end else if (load_valid) begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (&wr_ptr_q) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                state_d = RUN;
            end
            RUN: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Output decode, registered state only apart from the restart term
    always_comb begin
        cpu_n_reset = (state_q == RUN);
        loading     = (state_q == LOAD);
        load_done   = (state_q == RELEASE);
        load_ready  = (state_q == LOAD) && !load_start;
    end

    // Instruction storage, cleared on reset
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= load_data;
        end
    end

    assign data = mem_q[addr];

endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory: directed self-checking bench for program_memory.
// Hand-computed expectations for load, restart, reload and reset cases.
module tb_program_memory;

    logic       clk;
    logic       reset;
    logic [3:0] addr;
    logic [7:0] data;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       load_done;
    logic       loading;
    logic       cpu_n_reset;

    int n_chk;
    int n_fail;
    int cyc2;
    int cyc3;
    int cyc5;

    program_memory #(
        .ADDR_W(4),
        .DATA_W(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .data       (data),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .loading    (loading),
        .cpu_n_reset(cpu_n_reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, input logic [7:0] exp, input string tag);
        addr = 4'(a);
        #1;
        chk(tag, 32'(data), 32'(exp));
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Feeds 16 bytes (base+i, or constant base) and counts cycles
    // until load_done appears.
    task automatic feed(input logic [7:0] base, input bit inc,
                        input bit gap, output int cyc);
        int  i;
        bit  acc;
        cyc = 0;
        i   = 0;
        while (!load_done && cyc < 100) begin
            load_valid = (i < 16) && !(gap && cyc[0]);
            load_data  = inc ? base + 8'(i) : base;
            #1;
            acc = load_valid && load_ready;
            tick();
            cyc++;
            if (acc) i++;
        end
        load_valid = 1'b0;
        chk("feed_done", 32'(load_done), 32'd1);
        chk("feed_count", 32'(i), 32'd16);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        addr       = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;

        // 1: reset mid-clock
        #7;
        reset = 1'b1;
        #1;
        chk("rst_nrst", 32'(cpu_n_reset), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        for (int a = 0; a < 16; a++) rd(a, 8'h00, "rst_mem");
        tick();
        tick();
        reset = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h77;
        for (int k = 0; k < 5; k++) tick();
        load_valid = 1'b0;
        chk("halt_nrst", 32'(cpu_n_reset), 32'd0);
        chk("halt_loading", 32'(loading), 32'd0);
        chk("halt_ready", 32'(load_ready), 32'd0);
        rd(0, 8'h00, "halt_drop");

        // 2: back-to-back load 30..3F
        start_load();
        chk("t2_loading", 32'(loading), 32'd1);
        chk("t2_nrst", 32'(cpu_n_reset), 32'd0);
        feed(8'h30, 1'b1, 1'b0, cyc2);
        chk("t2_cycles", 32'(cyc2), 32'd16);
        chk("t2_rel_nrst", 32'(cpu_n_reset), 32'd0);
        tick();
        chk("t2_done_pulse", 32'(load_done), 32'd0);
        chk("t2_run_nrst", 32'(cpu_n_reset), 32'd1);
        rd(5, 8'h35, "t2_addr5");

        // 3: same load with gaps
        start_load();
        chk("t3_nrst", 32'(cpu_n_reset), 32'd0);
        feed(8'h30, 1'b1, 1'b1, cyc3);
        chk("t3_delta", 32'(cyc3 - cyc2), 32'd15);
        tick();
        chk("t3_run", 32'(cpu_n_reset), 32'd1);
        for (int a = 0; a < 16; a++) rd(a, 8'h30 + 8'(a), "t3_mem");

        // 4: restart after 7 bytes
        start_load();
        for (int k = 0; k < 7; k++) begin
            load_valid = 1'b1;
            load_data  = 8'hA0 + 8'(k);
            tick();
        end
        load_start = 1'b1;
        load_data  = 8'hAA;
        #1;
        chk("t4_ready_low", 32'(load_ready), 32'd0);
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        rd(0, 8'hA0, "t4_not_taken");
        rd(6, 8'hA6, "t4_addr6");
        rd(7, 8'h37, "t4_addr7_old");
        rd(15, 8'h3F, "t4_addr15_old");
        load_valid = 1'b1;
        load_data  = 8'hB0;
        tick();
        load_valid = 1'b0;
        rd(0, 8'hB0, "t4_restart_addr0");
        rd(1, 8'hA1, "t4_addr1_kept");
        for (int k = 1; k < 15; k++) begin
            load_valid = 1'b1;
            load_data  = 8'hC0 + 8'(k);
            tick();
        end
        chk("t4_not_done", 32'(load_done), 32'd0);
        load_data = 8'hCF;
        tick();
        load_valid = 1'b0;
        chk("t4_done", 32'(load_done), 32'd1);
        tick();
        rd(15, 8'hCF, "t4_addr15_new");

        // 5: reload from RUN
        chk("t5_pre_nrst", 32'(cpu_n_reset), 32'd1);
        start_load();
        chk("t5_nrst_low", 32'(cpu_n_reset), 32'd0);
        feed(8'hF0, 1'b0, 1'b0, cyc5);
        tick();
        chk("t5_run", 32'(cpu_n_reset), 32'd1);
        for (int a = 0; a < 16; a++) rd(a, 8'hF0, "t5_mem");

        // 6: reset during LOAD after 9 bytes
        start_load();
        for (int k = 0; k < 9; k++) begin
            load_valid = 1'b1;
            load_data  = 8'h50 + 8'(k);
            tick();
        end
        load_valid = 1'b0;
        rd(8, 8'h58, "t6_partial");
        #2;
        reset = 1'b1;
        #1;
        chk("t6_nrst", 32'(cpu_n_reset), 32'd0);
        chk("t6_loading", 32'(loading), 32'd0);
        for (int a = 0; a < 16; a++) rd(a, 8'h00, "t6_mem");
        tick();
        reset = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (load_done) seen = 1'b1;
            end
            chk("t6_no_done", 32'(seen), 32'd0);
        end
        chk("t6_halt_loading", 32'(loading), 32'd0);
        chk("t6_halt_nrst", 32'(cpu_n_reset), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
